// File: rtl/bip2_pkg.sv
// Shared opcodes, FSM encoding, datapath select codes and control payload for the BIP2 control unit.
package bip2_pkg;

    localparam int unsigned OP_W    = 5;
    localparam int unsigned CYCLE_W = 32;

    localparam logic [OP_W-1:0] OP_HLT  = 5'b00000;
    localparam logic [OP_W-1:0] OP_STO  = 5'b00001;
    localparam logic [OP_W-1:0] OP_LD   = 5'b00010;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00011;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00100;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b00101;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00110;
    localparam logic [OP_W-1:0] OP_SUBI = 5'b00111;
    localparam logic [OP_W-1:0] OP_BEQ  = 5'b01000;
    localparam logic [OP_W-1:0] OP_BNE  = 5'b01001;
    localparam logic [OP_W-1:0] OP_JMP  = 5'b01010;

    localparam logic [1:0] SELA_RAM = 2'd0;
    localparam logic [1:0] SELA_IMM = 2'd1;
    localparam logic [1:0] SELA_ALU = 2'd2;
    localparam logic       SELB_RAM = 1'b0;
    localparam logic       SELB_IMM = 1'b1;
    localparam logic       ALU_ADD  = 1'b0;
    localparam logic       ALU_SUB  = 1'b1;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       wr_acc;
        logic       op;
        logic       wr_ram;
        logic       rd_ram;
    } ctrl_t;

endpackage

// File: rtl/bip2_decoder.sv
// Combinational instruction decode: datapath controls, branch-taken and halt flags, all idle outside EXEC.
module bip2_decoder
    import bip2_pkg::*;
#(
    parameter int unsigned OPLEN = 5
) (
    input  logic [OPLEN-1:0] opcode,
    input  logic             exec,
    input  logic             acc_zero,
    output ctrl_t            ctrl,
    output logic             branch_taken,
    output logic             is_halt
);

    always_comb begin
        ctrl         = '0;
        branch_taken = 1'b0;
        is_halt      = 1'b0;
        if (exec) begin
            case (opcode)
                OPLEN'(OP_HLT):  is_halt = 1'b1;
                OPLEN'(OP_STO):  ctrl.wr_ram = 1'b1;
                OPLEN'(OP_LD): begin
                    ctrl.rd_ram = 1'b1;
                    ctrl.sel_a  = SELA_RAM;
                    ctrl.wr_acc = 1'b1;
                end
                OPLEN'(OP_LDI): begin
                    ctrl.sel_a  = SELA_IMM;
                    ctrl.wr_acc = 1'b1;
                end
                OPLEN'(OP_ADD), OPLEN'(OP_SUB): begin
                    ctrl.rd_ram = 1'b1;
                    ctrl.sel_b  = SELB_RAM;
                    ctrl.op     = (opcode == OPLEN'(OP_SUB)) ? ALU_SUB : ALU_ADD;
                    ctrl.sel_a  = SELA_ALU;
                    ctrl.wr_acc = 1'b1;
                end
                OPLEN'(OP_ADDI), OPLEN'(OP_SUBI): begin
                    ctrl.sel_b  = SELB_IMM;
                    ctrl.op     = (opcode == OPLEN'(OP_SUBI)) ? ALU_SUB : ALU_ADD;
                    ctrl.sel_a  = SELA_ALU;
                    ctrl.wr_acc = 1'b1;
                end
                OPLEN'(OP_BEQ):  branch_taken = acc_zero;
                OPLEN'(OP_BNE):  branch_taken = ~acc_zero;
                OPLEN'(OP_JMP):  branch_taken = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bip2_control.sv
// BIP2 control unit: fetch/wait/exec/halt sequencer with PC, IR and branch handling.
// Optional cycle counter for debug readout is enabled with BIP2_CTRL_CYCLE_CNT_EN.
module bip2_control
    import bip2_pkg::*;
#(
    parameter int unsigned OPLEN = 5,
    parameter int unsigned ADDR  = 11,
    parameter int unsigned IBITS = OPLEN + ADDR
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IBITS-1:0] i_instdata,
    input  logic             i_inst_valid,
    input  logic             i_acc_zero,
    output logic             o_fetch,
    output logic [ADDR-1:0]  o_addr_pm,
    output logic [ADDR-1:0]  o_operand,
    output logic [1:0]       o_selA,
    output logic             o_selB,
    output logic             o_wrAcc,
    output logic             o_op,
    output logic             o_wrRam,
    output logic             o_rdRam,
    output logic             o_halt
`ifdef BIP2_CTRL_CYCLE_CNT_EN
   ,output logic [CYCLE_W-1:0] o_cycles
`endif
);

    state_t            state, state_d;
    logic [ADDR-1:0]   pc, pc_d;
    logic [IBITS-1:0]  ir, ir_d;
    ctrl_t             ctrl;
    logic              branch_taken;
    logic              is_halt;
    logic [ADDR-1:0]   operand;

    assign operand = ir[ADDR-1:0];

    bip2_decoder #(
        .OPLEN (OPLEN)
    ) u_decoder (
        .opcode       (ir[IBITS-1 -: OPLEN]),
        .exec         (state == ST_EXEC),
        .acc_zero     (i_acc_zero),
        .ctrl         (ctrl),
        .branch_taken (branch_taken),
        .is_halt      (is_halt)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= ST_FETCH;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            ir    <= ir_d;
        end
    end

    // Next state; the PC only moves on the edge that ends EXEC (HLT leaves it on the halting instruction)
    always_comb begin
        state_d = state;
        pc_d    = pc;
        ir_d    = ir;
        case (state)
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (i_inst_valid) begin
                    ir_d    = i_instdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_halt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                    pc_d    = branch_taken ? operand : pc + ADDR'(1);
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    assign o_fetch   = (state == ST_FETCH);
    assign o_halt    = (state == ST_HALT);
    assign o_addr_pm = pc;
    assign o_operand = operand;
    assign o_selA    = ctrl.sel_a;
    assign o_selB    = ctrl.sel_b;
    assign o_wrAcc   = ctrl.wr_acc;
    assign o_op      = ctrl.op;
    assign o_wrRam   = ctrl.wr_ram;
    assign o_rdRam   = ctrl.rd_ram;

`ifdef BIP2_CTRL_CYCLE_CNT_EN
    logic [CYCLE_W-1:0] cycles;

    // Saturating run-time counter, frozen once halted
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cycles <= '0;
        end else if (state != ST_HALT && cycles != '1) begin
            cycles <= cycles + CYCLE_W'(1);
        end
    end

    assign o_cycles = cycles;
`endif

endmodule
